i2c_target_rx: RTL

I2C_TARGET_RX -- requirements
Module: i2c_target_rx

---
 rtl/i2c_pkg.sv | 28 ++
 rtl/i2c_line_sync.sv | 31 +++
 rtl/i2c_target_rx.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C receive-only target.
package i2c_pkg;

    // Bus-protocol position of the target.
    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StData,
        StDataAck,
        StIgnore
    } i2c_state_e;

    // Value driven on sda_oe: 1 pulls SDA low (ACK), 0 releases it (NACK).
    localparam logic AckLevel  = 1'b1;
    localparam logic NackLevel = 1'b0;

    localparam logic [6:0] DefaultTargetAddr = 7'h50;

    // R/W bit value of a write request; reads are never acknowledged.
    localparam logic RwWrite = 1'b0;

    // True when an address byte selects this target for a write.
    function automatic logic addr_hit(input logic [7:0] addr_byte, input logic [6:0] target);
        return (addr_byte[7:1] == target) && (addr_byte[0] == RwWrite);
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizer for one open-drain bus line with rise/fall pulse outputs.
module i2c_line_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst,
    input  logic line,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Sync chain plus one extra copy for edge detection; reset to idle-high bus level.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], line};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/i2c_target_rx.sv
// Receive-only I2C target: matches a 7-bit write address and collects data bytes.
module i2c_target_rx
    import i2c_pkg::*;
#(
    parameter logic [6:0]  TARGET_ADDR = DefaultTargetAddr,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       start_det,
    output logic       stop_det,
    output logic       busy
);

    logic scl_level, scl_rise, scl_fall;
    logic sda_level, sda_rise, sda_fall;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
        .clk_in (clk_in),
        .rst    (rst),
        .line   (scl_in),
        .level  (scl_level),
        .rise   (scl_rise),
        .fall   (scl_fall)
    );

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
        .clk_in (clk_in),
        .rst    (rst),
        .line   (sda_in),
        .level  (sda_level),
        .rise   (sda_rise),
        .fall   (sda_fall)
    );

    i2c_state_e state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       start_det_q, stop_det_q;
    // In StAddr/StData: all 8 bits shifted in, waiting for SCL fall.
    // In the ACK states: 9th SCL rise seen, waiting for its fall.
    logic       phase_q, phase_d;
    logic       start_ev, stop_ev;

    assign start_ev = sda_fall & scl_level;
    assign stop_ev  = sda_rise & scl_level;

    // State and datapath registers.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 3'd0;
            shift_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            start_det_q <= 1'b0;
            stop_det_q  <= 1'b0;
            phase_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            start_det_q <= start_ev;
            stop_det_q  <= stop_ev;
            phase_q     <= phase_d;
        end
    end

    // Next-state logic; START/STOP override any SCL-edge handling.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        phase_d    = phase_q;
        if (start_ev) begin
            state_d = StAddr;
            cnt_d   = 3'd0;
            shift_d = 8'h00;
            phase_d = 1'b0;
        end else if (stop_ev) begin
            state_d = StIdle;
            cnt_d   = 3'd0;
            phase_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StIgnore: ;
                StAddr, StData: begin
                    if (scl_rise && !phase_q) begin
                        shift_d = {shift_q[6:0], sda_level};
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            phase_d = 1'b1;
                            if (state_q == StData) begin
                                rx_data_d  = shift_d;
                                rx_valid_d = 1'b1;
                            end
                        end
                    end else if (scl_fall && phase_q) begin
                        phase_d = 1'b0;
                        if (state_q == StAddr) begin
                            state_d = addr_hit(shift_q, TARGET_ADDR) ? StAddrAck : StIgnore;
                        end else begin
                            state_d = StDataAck;
                        end
                    end
                end
                StAddrAck, StDataAck: begin
                    if (scl_rise) begin
                        phase_d = 1'b1;
                    end else if (scl_fall && phase_q) begin
                        state_d = StData;
                        cnt_d   = 3'd0;
                        shift_d = 8'h00;
                        phase_d = 1'b0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // SDA is pulled only while an ACK slot is owned; any exit from it releases the line.
    always_comb begin
        sda_oe = ((state_q == StAddrAck) || (state_q == StDataAck)) ? AckLevel : NackLevel;
        busy   = (state_q != StIdle);
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign start_det = start_det_q;
    assign stop_det  = stop_det_q;

endmodule
